// File: rtl/scoreboard_ctrl.sv
// rtl/scoreboard_ctrl.sv - run sequencer and statistics snapshot for the scoreboard datapath
module scoreboard_ctrl #(
    parameter int DRAIN_CYCLES = 8,
    parameter int CTR_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [31:0]          i_target,
    input  logic [31:0]          i_err_limit,
    input  logic [31:0]          i_data_ctr,
    input  logic [31:0]          i_error_ctr,
    input  logic [31:0]          i_maxacc,
    input  logic [31:0]          i_minacc,
    input  logic                 i_snap_req,
    output logic                 o_sb_reset,
    output logic                 o_freeze,
    output logic                 o_gen_en,
    output logic [2:0]           o_state,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_stop_cause,
    output logic [31:0]          o_snap_data,
    output logic [31:0]          o_snap_error,
    output logic [31:0]          o_snap_maxacc,
    output logic [31:0]          o_snap_minacc,
    output logic                 o_snap_ack,
    output logic [CTR_WIDTH-1:0] o_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Drain counter counts DRAIN_CYCLES-1 down to 0, so DRAIN lasts DRAIN_CYCLES cycles.
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]       DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
    localparam logic [DCW-1:0]       DRAIN_DEC  = DCW'(1);
    localparam logic [CTR_WIDTH-1:0] CYC_INC    = CTR_WIDTH'(1);

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     cause_d;
    logic           start_ok;
    logic [31:0]    target_q;
    logic [31:0]    limit_q;
    logic [DCW-1:0] drain_q;
    logic           snap_req_q;
    logic           snap_capture;

    assign o_state = state_q;

    // Next state and stop cause; abort outranks error limit, which outranks target.
    always_comb begin
        state_d  = state_q;
        cause_d  = o_stop_cause;
        start_ok = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d  = ST_CLEAR;
                    cause_d  = 2'b00;
                    start_ok = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_d = ST_DONE;
                    cause_d = 2'b11;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_d = ST_DONE;
                    cause_d = 2'b11;
                end else if ((limit_q != 32'd0) && (i_error_ctr >= limit_q)) begin
                    state_d = ST_DRAIN;
                    cause_d = 2'b10;
                end else if ((target_q != 32'd0) && (i_data_ctr >= target_q)) begin
                    state_d = ST_DRAIN;
                    cause_d = 2'b01;
                end
            end
            ST_DRAIN: begin
                if (i_abort || (drain_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and control outputs decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            o_stop_cause <= 2'b00;
            o_sb_reset   <= 1'b1;
            o_freeze     <= 1'b1;
            o_gen_en     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_stop_cause <= cause_d;
            o_sb_reset   <= (state_d == ST_CLEAR);
            o_freeze     <= !((state_d == ST_RUN) || (state_d == ST_DRAIN));
            o_gen_en     <= (state_d == ST_RUN);
            o_busy       <= (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            o_done       <= (state_d == ST_DONE);
        end
    end

    // Run parameters latched on start; cycle counter counts RUN cycles and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= 32'd0;
            limit_q  <= 32'd0;
            o_cycles <= '0;
        end else begin
            if (start_ok) begin
                target_q <= i_target;
                limit_q  <= i_err_limit;
                o_cycles <= '0;
            end else if ((state_q == ST_RUN) && (o_cycles != '1)) begin
                o_cycles <= o_cycles + CYC_INC;
            end
        end
    end

    // Drain timer is held loaded outside DRAIN and counts down while draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_q <= DRAIN_LOAD;
        end else if (state_q != ST_DRAIN) begin
            drain_q <= DRAIN_LOAD;
        end else if (drain_q != '0) begin
            drain_q <= drain_q - DRAIN_DEC;
        end
    end

    // One capture per request rising edge or DONE entry; both together still give one ack.
    assign snap_capture = (i_snap_req && !snap_req_q) ||
                          ((state_d == ST_DONE) && (state_q != ST_DONE));

    // Snapshot registers and the acknowledge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_req_q    <= 1'b0;
            o_snap_ack    <= 1'b0;
            o_snap_data   <= 32'd0;
            o_snap_error  <= 32'd0;
            o_snap_maxacc <= 32'd0;
            o_snap_minacc <= 32'd0;
        end else begin
            snap_req_q <= i_snap_req;
            o_snap_ack <= snap_capture;
            if (snap_capture) begin
                o_snap_data   <= i_data_ctr;
                o_snap_error  <= i_error_ctr;
                o_snap_maxacc <= i_maxacc;
                o_snap_minacc <= i_minacc;
            end
        end
    end

endmodule
